// File: rtl/redmule_z_drain_if.sv
// Fill/drain handshake bundle for redmule_z_drain: result-column fill side,
// row-word drain side, tile leftovers and occupancy flags.
interface redmule_z_drain_if #(
  parameter int unsigned DW   = 288,
  parameter int unsigned BITW = 16,
  parameter int unsigned W    = 12
);
  localparam int unsigned L  = DW / BITW;
  localparam int unsigned CW = $clog2(L) + 1;
  localparam int unsigned RW = $clog2(W) + 1;

  logic [CW-1:0]     cols_lftovr_i;
  logic [RW-1:0]     rows_lftovr_i;
  logic              fill_valid_i;
  logic              fill_ready_o;
  logic [W*BITW-1:0] z_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DW-1:0]     out_data_o;
  logic [DW/8-1:0]   out_strb_o;
  logic              out_last_o;
  logic              full_o;
  logic              empty_o;

  modport slave (
    input  cols_lftovr_i, rows_lftovr_i, fill_valid_i, z_i, out_ready_i,
    output fill_ready_o, out_valid_o, out_data_o, out_strb_o, out_last_o,
           full_o, empty_o
  );

  modport master (
    output cols_lftovr_i, rows_lftovr_i, fill_valid_i, z_i, out_ready_i,
    input  fill_ready_o, out_valid_o, out_data_o, out_strb_o, out_last_o,
           full_o, empty_o
  );
endinterface

// File: rtl/redmule_z_drain.sv
// Z output buffer: gathers W-element result columns into a WxL tile, then drains it row by row
// as masked DW-bit words. Define REDMULE_Z_DRAIN_DBUF_EN for two ping-pong banks.
module redmule_z_drain #(
  parameter int unsigned DW    = 288,
  parameter int unsigned BITW  = 16,  // element width, FP16 by default
  parameter int unsigned Width = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  redmule_z_drain_if.slave io
);
  localparam int unsigned W   = Width;
  localparam int unsigned L   = DW / BITW;
  localparam int unsigned BPE = BITW / 8;
  localparam int unsigned CW  = $clog2(L) + 1;
  localparam int unsigned RW  = $clog2(W) + 1;
  localparam int unsigned CIW = $clog2(L);
  localparam int unsigned RIW = $clog2(W);
`ifdef REDMULE_Z_DRAIN_DBUF_EN
  localparam int unsigned NB = 2;
`else
  localparam int unsigned NB = 1;
`endif

  typedef enum logic {ST_FILL, ST_DRAIN} state_e;

  state_e          state_q   [NB];
  state_e          state_d   [NB];
  logic [CW-1:0]   col_lim_q [NB];
  logic [CW-1:0]   col_lim_d [NB];
  logic [RW-1:0]   row_lim_q [NB];
  logic [RW-1:0]   row_lim_d [NB];
  logic [CIW-1:0]  col_idx_q, col_idx_d;
  logic [RIW-1:0]  row_idx_q, row_idx_d;
  logic [BITW-1:0] mem_q [NB][W][L];

  logic [NB-1:0]   fill_oh, drain_oh;
  logic            soft_rst;
  logic            fill_is_fill, drain_is_drain, any_drain;
  logic [CW-1:0]   fill_col_lim, drain_col_lim, cols_dec, rows_dec_ext, cur_col_lim;
  logic [RW-1:0]   drain_row_lim, rows_dec;
  logic            fill_hs, out_hs, first_fill, fill_last, drain_last;
  logic            fill_done, drain_done;
  logic [DW-1:0]   word_data;
  logic [DW/8-1:0] word_strb;

  assign soft_rst = rst_i | clear_i;

`ifdef REDMULE_Z_DRAIN_DBUF_EN
  // Banks complete in alternation, so toggling pointers keeps drain order = completion order.
  logic fill_sel_q, fill_sel_d, drain_sel_q, drain_sel_d;

  assign fill_sel_d  = fill_sel_q ^ fill_done;
  assign drain_sel_d = drain_sel_q ^ drain_done;
  assign fill_oh     = fill_sel_q  ? 2'b10 : 2'b01;
  assign drain_oh    = drain_sel_q ? 2'b10 : 2'b01;

  always_ff @(posedge clk_i) begin
    if (soft_rst) begin
      fill_sel_q  <= 1'b0;
      drain_sel_q <= 1'b0;
    end else begin
      fill_sel_q  <= fill_sel_d;
      drain_sel_q <= drain_sel_d;
    end
  end
`else
  assign fill_oh  = 1'b1;
  assign drain_oh = 1'b1;
`endif

  always_comb begin
    fill_is_fill   = 1'b0;
    fill_col_lim   = '0;
    drain_is_drain = 1'b0;
    drain_col_lim  = '0;
    drain_row_lim  = '0;
    any_drain      = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (state_q[b] == ST_DRAIN) any_drain = 1'b1;
      if (fill_oh[b]) begin
        fill_is_fill = (state_q[b] == ST_FILL);
        fill_col_lim = col_lim_q[b];
      end
      if (drain_oh[b]) begin
        drain_is_drain = (state_q[b] == ST_DRAIN);
        drain_col_lim  = col_lim_q[b];
        drain_row_lim  = row_lim_q[b];
      end
    end
  end

  assign cols_dec     = (io.cols_lftovr_i == '0) ? CW'(L) : io.cols_lftovr_i;
  assign rows_dec     = (io.rows_lftovr_i == '0) ? RW'(W) : io.rows_lftovr_i;
  assign rows_dec_ext = CW'(rows_dec);
  assign fill_hs      = io.fill_valid_i & fill_is_fill;
  assign out_hs       = drain_is_drain & io.out_ready_i;
  assign first_fill   = (col_idx_q == '0);
  // The first column of a tile must already see the fresh limit (tiles may be one column wide).
  assign cur_col_lim  = first_fill ? cols_dec : fill_col_lim;
  assign fill_last    = ({1'b0, col_idx_q} == cur_col_lim - CW'(1));
  assign drain_last   = ({1'b0, row_idx_q} == drain_row_lim - RW'(1));
  assign fill_done    = fill_hs & fill_last;
  assign drain_done   = out_hs & drain_last;

  always_comb begin
    col_idx_d = col_idx_q;
    row_idx_d = row_idx_q;
    if (fill_hs) col_idx_d = fill_last ? '0 : col_idx_q + CIW'(1);
    if (out_hs)  row_idx_d = drain_last ? '0 : row_idx_q + RIW'(1);
    for (int b = 0; b < NB; b++) begin
      state_d[b]   = state_q[b];
      col_lim_d[b] = col_lim_q[b];
      row_lim_d[b] = row_lim_q[b];
      if (fill_oh[b] && fill_hs && first_fill) begin
        col_lim_d[b] = cols_dec;
        row_lim_d[b] = rows_dec;
      end
      if (fill_oh[b] && fill_done)   state_d[b] = ST_DRAIN;
      if (drain_oh[b] && drain_done) state_d[b] = ST_FILL;
    end
  end

  always_ff @(posedge clk_i) begin
    if (soft_rst) begin
      col_idx_q <= '0;
      row_idx_q <= '0;
      for (int b = 0; b < NB; b++) begin
        state_q[b]   <= ST_FILL;
        col_lim_q[b] <= CW'(L);
        row_lim_q[b] <= RW'(W);
      end
    end else begin
      col_idx_q <= col_idx_d;
      row_idx_q <= row_idx_d;
      for (int b = 0; b < NB; b++) begin
        state_q[b]   <= state_d[b];
        col_lim_q[b] <= col_lim_d[b];
        row_lim_q[b] <= row_lim_d[b];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (soft_rst) begin
      for (int b = 0; b < NB; b++)
        for (int w = 0; w < W; w++)
          for (int c = 0; c < L; c++)
            mem_q[b][w][c] <= '0;
    end else begin
      for (int b = 0; b < NB; b++)
        for (int w = 0; w < W; w++)
          if (fill_oh[b] && fill_hs) mem_q[b][w][col_idx_q] <= io.z_i[w*BITW +: BITW];
    end
  end

  // Columns past the leftover limit are zeroed and unstrobed; the whole word is 0 while idle.
  always_comb begin
    word_data = '0;
    word_strb = '0;
    if (drain_is_drain) begin
      for (int c = 0; c < L; c++) begin
        if (CW'(c) < drain_col_lim) begin
          word_strb[c*BPE +: BPE] = '1;
          for (int b = 0; b < NB; b++)
            if (drain_oh[b]) word_data[c*BITW +: BITW] = mem_q[b][row_idx_q][c];
        end
      end
    end
  end

  assign io.fill_ready_o = fill_is_fill;
  assign io.full_o       = ~fill_is_fill;
  assign io.empty_o      = ~any_drain & first_fill;
  assign io.out_valid_o  = drain_is_drain;
  assign io.out_data_o   = word_data;
  assign io.out_strb_o   = word_strb;
  assign io.out_last_o   = drain_is_drain & drain_last;

  logic unused_lim;
  assign unused_lim = ^rows_dec_ext;
endmodule

// File: tb/tb_redmule_z_drain.sv
// Directed bench for redmule_z_drain (W=12, L=18, FP16); one line per checked transaction.
module tb_redmule_z_drain;
  localparam int DW = 288, BITW = 16, W = 12, L = 18;

  logic clk = 1'b0;
  logic rst, clear;
  int   total = 0, bad = 0;

  always #5 clk = ~clk;

  redmule_z_drain_if #(.DW(DW), .BITW(BITW), .W(W)) zif ();
  redmule_z_drain #(.DW(DW), .BITW(BITW), .Width(W)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .io(zif)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] exp_word(int r, int ncols, int base);
    logic [DW-1:0] v = '0;
    for (int c = 0; c < ncols; c++) v[c*BITW +: BITW] = 16'(base + r*18 + c);
    return v;
  endfunction

  function automatic logic [DW/8-1:0] exp_strb(int ncols);
    logic [DW/8-1:0] v = '0;
    for (int c = 0; c < ncols; c++) v[c*2 +: 2] = 2'b11;
    return v;
  endfunction

  function automatic logic [W*BITW-1:0] make_z(int c, int base);
    logic [W*BITW-1:0] v = '0;
    for (int w = 0; w < W; w++) v[w*BITW +: BITW] = 16'(base + w*18 + c);
    return v;
  endfunction

  // Leftovers are presented only on the first column, then forced to 0 to exercise the latch.
  task automatic fill_cols(int cl, int rl, int c0, int c1, int base);
    for (int c = c0; c <= c1; c++) begin
      zif.fill_valid_i  = 1'b1;
      zif.z_i           = make_z(c, base);
      zif.cols_lftovr_i = (c == 0) ? 6'(cl) : 6'd0;
      zif.rows_lftovr_i = (c == 0) ? 5'(rl) : 5'd0;
      tick();
    end
    zif.fill_valid_i  = 1'b0;
    zif.cols_lftovr_i = 6'd0;
    zif.rows_lftovr_i = 5'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0;
    zif.fill_valid_i = 1'b0; zif.out_ready_i = 1'b0; zif.z_i = '0;
    zif.cols_lftovr_i = '0; zif.rows_lftovr_i = '0;
    repeat (3) tick();
    rst = 1'b0;
    total += 7;
    if (zif.fill_ready_o !== 1'b1) begin bad++; $display("FAIL reset_fill_ready got=%b want=1", zif.fill_ready_o); end
    if (zif.out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", zif.out_valid_o); end
    if (zif.out_data_o !== '0) begin bad++; $display("FAIL reset_out_data got=%h want=0", zif.out_data_o); end
    if (zif.out_strb_o !== '0) begin bad++; $display("FAIL reset_out_strb got=%h want=0", zif.out_strb_o); end
    if (zif.out_last_o !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b want=0", zif.out_last_o); end
    if (zif.full_o !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", zif.full_o); end
    if (zif.empty_o !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", zif.empty_o); end
    $display("reset: checked");
  endtask

  task automatic test_full_tile();
    zif.out_ready_i = 1'b1;
    fill_cols(0, 0, 0, 16, 0);
    total += 2;
    if (zif.out_valid_o !== 1'b0) begin bad++; $display("FAIL full_early_valid got=%b want=0", zif.out_valid_o); end
    if (zif.fill_ready_o !== 1'b1) begin bad++; $display("FAIL full_fill_ready got=%b want=1", zif.fill_ready_o); end
    fill_cols(0, 0, 17, 17, 0);
`ifndef REDMULE_Z_DRAIN_DBUF_EN
    total++;
    if (zif.fill_ready_o !== 1'b0) begin bad++; $display("FAIL full_turnaround_ready got=%b want=0", zif.fill_ready_o); end
`endif
    for (int r = 0; r < 12; r++) begin
      total += 4;
      if (zif.out_valid_o !== 1'b1) begin bad++; $display("FAIL full_valid row=%0d got=%b want=1", r, zif.out_valid_o); end
      if (zif.out_data_o !== exp_word(r, 18, 0)) begin bad++; $display("FAIL full_data row=%0d got=%h want=%h", r, zif.out_data_o, exp_word(r, 18, 0)); end
      if (zif.out_strb_o !== {36{1'b1}}) begin bad++; $display("FAIL full_strb row=%0d got=%h want=all ones", r, zif.out_strb_o); end
      if (zif.out_last_o !== (r == 11)) begin bad++; $display("FAIL full_last row=%0d got=%b want=%b", r, zif.out_last_o, r == 11); end
      $display("full tile: word %0d", r);
      tick();
    end
    total += 3;
    if (zif.out_valid_o !== 1'b0) begin bad++; $display("FAIL full_after_valid got=%b want=0", zif.out_valid_o); end
    if (zif.fill_ready_o !== 1'b1) begin bad++; $display("FAIL full_after_ready got=%b want=1", zif.fill_ready_o); end
    if (zif.empty_o !== 1'b1) begin bad++; $display("FAIL full_after_empty got=%b want=1", zif.empty_o); end
  endtask

  task automatic test_leftover();
    zif.out_ready_i = 1'b1;
    fill_cols(5, 3, 0, 4, 256);
    for (int r = 0; r < 3; r++) begin
      total += 4;
      if (zif.out_valid_o !== 1'b1) begin bad++; $display("FAIL lft_valid row=%0d got=%b want=1", r, zif.out_valid_o); end
      if (zif.out_data_o !== exp_word(r, 5, 256)) begin bad++; $display("FAIL lft_data row=%0d got=%h want=%h", r, zif.out_data_o, exp_word(r, 5, 256)); end
      if (zif.out_strb_o !== 36'h3FF) begin bad++; $display("FAIL lft_strb row=%0d got=%h want=3ff", r, zif.out_strb_o); end
      if (zif.out_last_o !== (r == 2)) begin bad++; $display("FAIL lft_last row=%0d got=%b want=%b", r, zif.out_last_o, r == 2); end
      $display("leftover: word %0d", r);
      tick();
    end
    total++;
    if (zif.out_valid_o !== 1'b0) begin bad++; $display("FAIL lft_extra_row got=%b want=0", zif.out_valid_o); end
  endtask

  task automatic test_backpressure();
    zif.out_ready_i = 1'b0;
    fill_cols(0, 4, 0, 17, 512);
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 3; k++) begin
        zif.out_ready_i = (k == 2);
        total += 3;
        if (zif.out_valid_o !== 1'b1) begin bad++; $display("FAIL bp_valid row=%0d k=%0d got=%b want=1", r, k, zif.out_valid_o); end
        if (zif.out_data_o !== exp_word(r, 18, 512)) begin bad++; $display("FAIL bp_data row=%0d k=%0d got=%h want=%h", r, k, zif.out_data_o, exp_word(r, 18, 512)); end
        if (zif.out_last_o !== (r == 3)) begin bad++; $display("FAIL bp_last row=%0d k=%0d got=%b want=%b", r, k, zif.out_last_o, r == 3); end
        tick();
      end
      $display("backpressure: word %0d", r);
    end
    zif.out_ready_i = 1'b0;
    total++;
    if (zif.out_valid_o !== 1'b0) begin bad++; $display("FAIL bp_extra_row got=%b want=0", zif.out_valid_o); end
  endtask

`ifndef REDMULE_Z_DRAIN_DBUF_EN
  task automatic test_fill_while_drain();
    zif.out_ready_i = 1'b0;
    fill_cols(3, 2, 0, 2, 1024);
    zif.fill_valid_i = 1'b1;
    zif.z_i = make_z(9, 16'h7000);
    for (int k = 0; k < 4; k++) begin
      zif.out_ready_i = (k >= 2);
      total += 3;
      if (zif.fill_ready_o !== 1'b0) begin bad++; $display("FAIL fwd_ready k=%0d got=%b want=0", k, zif.fill_ready_o); end
      if (zif.full_o !== 1'b1) begin bad++; $display("FAIL fwd_full k=%0d got=%b want=1", k, zif.full_o); end
      if (zif.out_data_o !== exp_word(k >= 3 ? 1 : 0, 3, 1024)) begin bad++; $display("FAIL fwd_data k=%0d got=%h want=%h", k, zif.out_data_o, exp_word(k >= 3 ? 1 : 0, 3, 1024)); end
      tick();
    end
    zif.fill_valid_i = 1'b0;
    total++;
    if (zif.fill_ready_o !== 1'b1) begin bad++; $display("FAIL fwd_ready_rise got=%b want=1", zif.fill_ready_o); end
    fill_cols(3, 2, 0, 2, 1536);
    for (int r = 0; r < 2; r++) begin
      total++;
      if (zif.out_data_o !== exp_word(r, 3, 1536)) begin bad++; $display("FAIL fwd_next_data row=%0d got=%h want=%h", r, zif.out_data_o, exp_word(r, 3, 1536)); end
      $display("fill-while-drain: word %0d", r);
      tick();
    end
    zif.out_ready_i = 1'b0;
  endtask
`endif

  task automatic test_clear();
    zif.out_ready_i = 1'b1;
    fill_cols(0, 0, 0, 17, 2048);
    for (int r = 0; r < 4; r++) begin
      total++;
      if (zif.out_data_o !== exp_word(r, 18, 2048)) begin bad++; $display("FAIL clr_pre_data row=%0d got=%h want=%h", r, zif.out_data_o, exp_word(r, 18, 2048)); end
      tick();
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total += 5;
    if (zif.out_valid_o !== 1'b0) begin bad++; $display("FAIL clr_valid got=%b want=0", zif.out_valid_o); end
    if (zif.empty_o !== 1'b1) begin bad++; $display("FAIL clr_empty got=%b want=1", zif.empty_o); end
    if (zif.fill_ready_o !== 1'b1) begin bad++; $display("FAIL clr_ready got=%b want=1", zif.fill_ready_o); end
    if (zif.out_data_o !== '0) begin bad++; $display("FAIL clr_data got=%h want=0", zif.out_data_o); end
    if (zif.out_strb_o !== '0) begin bad++; $display("FAIL clr_strb got=%h want=0", zif.out_strb_o); end
    fill_cols(2, 2, 0, 1, 3072);
    for (int r = 0; r < 2; r++) begin
      total += 2;
      if (zif.out_data_o !== exp_word(r, 2, 3072)) begin bad++; $display("FAIL clr_post_data row=%0d got=%h want=%h", r, zif.out_data_o, exp_word(r, 2, 3072)); end
      if (zif.out_last_o !== (r == 1)) begin bad++; $display("FAIL clr_post_last row=%0d got=%b want=%b", r, zif.out_last_o, r == 1); end
      $display("clear: word %0d", r);
      tick();
    end
  endtask

`ifdef REDMULE_Z_DRAIN_DBUF_EN
  task automatic test_back_to_back();
    logic [DW-1:0] got_data [$];
    int            got_cyc  [$];
    int            k = 0;
    zif.out_ready_i = 1'b1;
    while (got_data.size() < 24 && k < 100) begin
      zif.fill_valid_i  = (k < 36);
      zif.z_i           = make_z(k % 18, (k < 18) ? 4096 : 8192);
      zif.cols_lftovr_i = 6'd0;
      zif.rows_lftovr_i = 5'd0;
      if (k < 36) begin
        total++;
        if (zif.fill_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready cyc=%0d got=%b want=1", k, zif.fill_ready_o); end
      end
      if (zif.out_valid_o === 1'b1) begin
        got_data.push_back(zif.out_data_o);
        got_cyc.push_back(k);
      end
      tick();
      k++;
    end
    zif.fill_valid_i = 1'b0;
    total++;
    if (got_data.size() != 24) begin bad++; $display("FAIL b2b_count got=%0d want=24", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < 24; i++) begin
      total += 2;
      if (got_data[i] !== exp_word(i % 12, 18, (i < 12) ? 4096 : 8192)) begin bad++; $display("FAIL b2b_data word=%0d got=%h want=%h", i, got_data[i], exp_word(i % 12, 18, (i < 12) ? 4096 : 8192)); end
      if (got_cyc[i] != ((i < 12) ? 18 + i : 24 + i)) begin bad++; $display("FAIL b2b_cycle word=%0d got=%0d want=%0d", i, got_cyc[i], (i < 12) ? 18 + i : 24 + i); end
      $display("back-to-back: word %0d at cycle %0d", i, got_cyc[i]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_tile();
    test_leftover();
    test_backpressure();
`ifndef REDMULE_Z_DRAIN_DBUF_EN
    test_fill_while_drain();
`endif
    test_clear();
`ifdef REDMULE_Z_DRAIN_DBUF_EN
    test_back_to_back();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
